// File: rtl/bop_pkg.sv
// Shared constants for the bop-it game: command codes, input count and FSM states.
// The game core imports the same codes, so encoder output and core stimulus compare directly.
package bop_pkg;

  localparam int unsigned NUM_INPUTS = 12;

  localparam logic [3:0] CODE_SW0   = 4'd0;
  localparam logic [3:0] CODE_SW1   = 4'd1;
  localparam logic [3:0] CODE_SW2   = 4'd2;
  localparam logic [3:0] CODE_SW3   = 4'd3;
  localparam logic [3:0] CODE_SW4   = 4'd4;
  localparam logic [3:0] CODE_SW5   = 4'd5;
  localparam logic [3:0] CODE_SW6   = 4'd6;
  localparam logic [3:0] CODE_SW7   = 4'd7;
  localparam logic [3:0] CODE_BTN_U = 4'd8;
  localparam logic [3:0] CODE_BTN_R = 4'd9;
  localparam logic [3:0] CODE_BTN_D = 4'd10;
  localparam logic [3:0] CODE_BTN_L = 4'd11;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    HOLD
  } state_t;

  // Event vectors are indexed by command code, so the lowest set bit is the winning code.
  function automatic logic [3:0] lowest_code(input logic [NUM_INPUTS-1:0] ev);
    logic [3:0] code;
    code = '0;
    for (int i = int'(NUM_INPUTS) - 1; i >= 0; i--) begin
      if (ev[i]) code = 4'(i);
    end
    return code;
  endfunction

  // Clearing the lowest set bit leaves something only when two or more bits were set.
  function automatic logic multi_event(input logic [NUM_INPUTS-1:0] ev);
    return |(ev & (ev - {{(NUM_INPUTS-1){1'b0}}, 1'b1}));
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One player input: 2-flop synchronizer, stability counter, debounced level and
// single-cycle rise/fall pulses registered on the same edge the debounced level changes.
module debounce_cell #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             stable_q;
  logic             rise_q;
  logic             fall_q;

  // Synchronize, count consecutive disagreeing cycles, and commit the new level with a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (sync_q[1] == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_q <= sync_q[1];
        cnt_q    <= '0;
        rise_q   <= sync_q[1];
        fall_q   <= ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;
  assign fall   = fall_q;

endmodule

// File: rtl/bop_input_encoder.sv
// Bop-it input front-end: debounces 4 buttons and 8 switches, turns press/flip events into
// a one-shot command code and hands it to the game core over a valid/ack handshake.
module bop_input_encoder
  import bop_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btnU,
  input  logic       btnR,
  input  logic       btnD,
  input  logic       btnL,
  input  logic [7:0] sw,
  input  logic       arm,
  input  logic       cmd_ack,
  output logic       cmd_valid,
  output logic [3:0] cmd_code,
  output logic       cmd_multi,
  output logic       cmd_overflow
);

  // Bit index equals command code: switches 0..7, then U, R, D, L.
  logic [NUM_INPUTS-1:0] raw;
  logic [NUM_INPUTS-1:0] stable;
  logic [NUM_INPUTS-1:0] rise;
  logic [NUM_INPUTS-1:0] fall;
  logic [NUM_INPUTS-1:0] ev;
  logic                  any_ev;
  state_t                state_q;

  assign raw = {btnL, btnD, btnR, btnU, sw};

  for (genvar i = 0; i < int'(NUM_INPUTS); i++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw[i]),
      .stable(stable[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

  // Switches report both flip directions; buttons report presses only.
  assign ev     = {rise[11:8], rise[7:0] | fall[7:0]};
  assign any_ev = |ev;

  // Debounced levels and button release pulses are not needed by the capture logic.
  logic unused_levels;
  assign unused_levels = ^{stable, fall[11:8]};

  // Capture FSM: arm gates capture, HOLD presents one code until acked, extras flag overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cmd_valid    <= 1'b0;
      cmd_code     <= '0;
      cmd_multi    <= 1'b0;
      cmd_overflow <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arm) begin
            state_q      <= ARMED;
            cmd_overflow <= 1'b0;
          end
        end
        ARMED: begin
          if (!arm) begin
            state_q <= IDLE;
          end else if (any_ev) begin
            state_q   <= HOLD;
            cmd_valid <= 1'b1;
            cmd_code  <= lowest_code(ev);
            cmd_multi <= multi_event(ev);
          end
        end
        HOLD: begin
          // An event coinciding with the ack is still dropped as overflow.
          if (any_ev) cmd_overflow <= 1'b1;
          if (cmd_ack) begin
            cmd_valid <= 1'b0;
            state_q   <= arm ? ARMED : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bop_input_encoder.sv
// Self-checking bench for bop_input_encoder with a short debounce window.
module tb_bop_input_encoder;

  localparam int D     = 4;
  localparam int CNT_W = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btnU, btnR, btnD, btnL;
  logic [7:0] sw;
  logic       arm;
  logic       cmd_ack;
  logic       cmd_valid;
  logic [3:0] cmd_code;
  logic       cmd_multi;
  logic       cmd_overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bop_input_encoder #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btnU        (btnU),
    .btnR        (btnR),
    .btnD        (btnD),
    .btnL        (btnL),
    .sw          (sw),
    .arm         (arm),
    .cmd_ack     (cmd_ack),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .cmd_multi   (cmd_multi),
    .cmd_overflow(cmd_overflow)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per input, a history of raw samples (bit 0 newest). A debounced level flips when the
  // synchronized samples (raw delayed by two edges) of the last D edges all disagree with it.
  logic [15:0] hist [12];
  logic [11:0] m_stable = '0;
  logic [11:0] m_ev     = '0;
  logic        m_armed  = 1'b0;
  logic        m_valid  = 1'b0;
  logic [3:0]  m_code   = '0;
  logic        m_multi  = 1'b0;
  logic        m_ovf    = 1'b0;
  logic [11:0] raw_now, new_ev;
  logic        all_diff;
  int          n_ev;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < 12; i++) hist[i] = '0;
        m_stable = '0;
        m_ev     = '0;
        m_armed  = 1'b0;
        m_valid  = 1'b0;
        m_code   = '0;
        m_multi  = 1'b0;
        m_ovf    = 1'b0;
      end else begin
        // Handshake reacts to the events that became visible at the previous edge.
        n_ev = $countones(m_ev);
        if (m_valid) begin
          if (n_ev > 0) m_ovf = 1'b1;
          if (cmd_ack) begin
            m_valid = 1'b0;
            m_armed = arm;
          end
        end else if (m_armed) begin
          if (!arm) begin
            m_armed = 1'b0;
          end else if (n_ev > 0) begin
            m_valid = 1'b1;
            m_multi = (n_ev > 1);
            for (int c = 11; c >= 0; c--) if (m_ev[c]) m_code = 4'(c);
          end
        end else if (arm) begin
          m_armed = 1'b1;
          m_ovf   = 1'b0;
        end
        raw_now = {btnL, btnD, btnR, btnU, sw};
        new_ev  = '0;
        for (int i = 0; i < 12; i++) begin
          hist[i]  = {hist[i][14:0], raw_now[i]};
          all_diff = 1'b1;
          for (int k = 2; k <= D + 1; k++) if (hist[i][k] == m_stable[i]) all_diff = 1'b0;
          if (all_diff) begin
            m_stable[i] = ~m_stable[i];
            new_ev[i]   = (i < 8) ? 1'b1 : m_stable[i];
          end
        end
        m_ev = new_ev;
      end
    end
  end

  // Compare every cycle on the falling edge, well away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("cyc_valid", cmd_valid, m_valid);
      check("cyc_code", cmd_code, m_code);
      check("cyc_multi", cmd_multi, m_multi);
      check("cyc_overflow", cmd_overflow, m_ovf);
    end
  end

  // ---------------- stimulus ----------------
  // All input changes happen 2 time units after a rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_ack(input string name);
    cmd_ack = 1'b1;
    step(1);
    cmd_ack = 1'b0;
    check(name, cmd_valid, 1'b0);
  endtask

  initial begin
    logic [11:0] r;
    int          elapsed;
    int          n;
    rst_n   = 1'b0;
    btnU    = 1'b0;
    btnR    = 1'b0;
    btnD    = 1'b0;
    btnL    = 1'b0;
    sw      = '0;
    arm     = 1'b0;
    cmd_ack = 1'b0;
    step(3);
    check("rst_valid", cmd_valid, 1'b0);
    check("rst_code", cmd_code, 4'd0);
    check("rst_multi", cmd_multi, 1'b0);
    check("rst_overflow", cmd_overflow, 1'b0);
    rst_n = 1'b1;

    // 1: clean btnR press, latency D+3 edges
    arm = 1'b1;
    step(2);
    btnR = 1'b1;
    step(D + 2);
    check("t1_early", cmd_valid, 1'b0);
    step(1);
    check("t1_valid", cmd_valid, 1'b1);
    check("t1_code", cmd_code, 4'd9);
    check("t1_multi", cmd_multi, 1'b0);
    step(3);
    check("t1_hold", cmd_valid, 1'b1);
    do_ack("t1_ack");
    btnR = 1'b0;
    step(D + 4);
    check("t1_release", cmd_valid, 1'b0);

    // 2: sw[3] bouncing with short pulses, then a clean hold
    elapsed = 0;
    while (elapsed < 40) begin
      sw[3] = ~sw[3];
      n = $urandom_range(1, 3);
      step(n);
      elapsed += n;
    end
    if (sw[3]) begin
      sw[3] = 1'b0;
      step(1);
    end
    check("t2_bounce", cmd_valid, 1'b0);
    sw[3] = 1'b1;
    step(D + 2);
    check("t2_early", cmd_valid, 1'b0);
    step(1);
    check("t2_valid", cmd_valid, 1'b1);
    check("t2_code", cmd_code, 4'd3);
    do_ack("t2_ack");
    sw[3] = 1'b0;
    step(D + 3);
    check("t2_off_valid", cmd_valid, 1'b1);
    check("t2_off_code", cmd_code, 4'd3);
    do_ack("t2_off_ack");

    // 3: simultaneous sw[5] flip and btnU press
    sw[5] = 1'b1;
    btnU  = 1'b1;
    step(D + 3);
    check("t3_valid", cmd_valid, 1'b1);
    check("t3_code", cmd_code, 4'd5);
    check("t3_multi", cmd_multi, 1'b1);
    do_ack("t3_ack");
    btnU = 1'b0;
    step(D + 4);

    // 4: overflow while holding code 0
    sw[0] = 1'b1;
    step(D + 3);
    check("t4_code0", cmd_code, 4'd0);
    check("t4_valid", cmd_valid, 1'b1);
    btnL = 1'b1;
    step(D + 3);
    check("t4_overflow", cmd_overflow, 1'b1);
    check("t4_code_kept", cmd_code, 4'd0);
    check("t4_still_valid", cmd_valid, 1'b1);
    do_ack("t4_ack");
    check("t4_sticky", cmd_overflow, 1'b1);
    arm = 1'b0;
    step(2);
    arm = 1'b1;
    step(2);
    check("t4_cleared", cmd_overflow, 1'b0);
    btnL = 1'b0;
    step(D + 4);

    // 5: events while disarmed are discarded
    arm = 1'b0;
    step(1);
    btnD  = 1'b1;
    sw[7] = 1'b1;
    step(10);
    check("t5_disarmed", cmd_valid, 1'b0);
    arm = 1'b1;
    step(10);
    check("t5_armed_quiet", cmd_valid, 1'b0);
    btnD = 1'b0;
    step(10);
    check("t5_release", cmd_valid, 1'b0);

    // 6: reset while holding, then sw[2] already high at release
    sw[1] = 1'b1;
    step(D + 3);
    check("t6_hold", cmd_valid, 1'b1);
    check("t6_code1", cmd_code, 4'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", cmd_valid, 1'b0);
    check("t6_rst_code", cmd_code, 4'd0);
    check("t6_rst_multi", cmd_multi, 1'b0);
    check("t6_rst_overflow", cmd_overflow, 1'b0);
    sw   = 8'b0000_0100;
    btnU = 1'b0;
    btnR = 1'b0;
    btnD = 1'b0;
    btnL = 1'b0;
    arm  = 1'b1;
    step(1);
    rst_n = 1'b1;
    step(D + 2);
    check("t6_early", cmd_valid, 1'b0);
    step(1);
    check("t6_valid", cmd_valid, 1'b1);
    check("t6_code2", cmd_code, 4'd2);
    do_ack("t6_ack");

    // Random traffic against the model, with one reset pulse in the middle
    for (int cyc = 0; cyc < 4000; cyc++) begin
      r = {btnL, btnD, btnR, btnU, sw};
      for (int i = 0; i < 12; i++) if ($urandom_range(0, 29) == 0) r[i] = ~r[i];
      {btnL, btnD, btnR, btnU, sw} = r;
      if ($urandom_range(0, 99) < 2) arm = ~arm;
      cmd_ack = ($urandom_range(0, 3) == 0);
      if (cyc == 2000) begin
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
      end
      step(1);
    end
    cmd_ack = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
